// File: rtl/washer_phase_if.sv
// Actuator-side signals between the washer controller FSM and its phase timer.
// The master drives actuator outputs and reads the done flags; the slave times the phases.
interface washer_phase_if;
  logic Water;
  logic Agitator;
  logic R;
  logic Pump;
  logic Motor;
  logic Door;
  logic Tf;
  logic Tw;
  logic Tr;
  logic Td;
  logic Ts;

  modport master (
    output Water, Agitator, R, Pump, Motor, Door,
    input  Tf, Tw, Tr, Td, Ts
  );

  modport slave (
    input  Water, Agitator, R, Pump, Motor, Door,
    output Tf, Tw, Tr, Td, Ts
  );
endinterface

// File: rtl/washer_phase_timer.sv
// Decodes the washer FSM's actuator outputs into a phase, times it with a prescaled
// tick counter and raises that phase's done flag once its duration has elapsed.
//
// state | meaning
// IDLE  | no actuator active; counters cleared, all flags low
// FILL  | Water on
// WASH  | Agitator on, R=0
// RINSE | Agitator on, R=1
// DRAIN | Pump on, Motor off
// SPIN  | Motor on; frozen while Door open
module washer_phase_timer #(
  parameter int TICK_DIV = 4,
  parameter int CW       = 16,
  parameter int FILL_T   = 3,
  parameter int WASH_T   = 4,
  parameter int RINSE_T  = 4,
  parameter int DRAIN_T  = 2,
  parameter int SPIN_T   = 5
) (
  input logic           clk,
  input logic           reset,
  washer_phase_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    DRAIN = 3'd4,
    SPIN  = 3'd5
  } phase_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  // A zero duration would otherwise never be reached before the first tick.
  localparam int FILL_E  = (FILL_T  < 1) ? 1 : FILL_T;
  localparam int WASH_E  = (WASH_T  < 1) ? 1 : WASH_T;
  localparam int RINSE_E = (RINSE_T < 1) ? 1 : RINSE_T;
  localparam int DRAIN_E = (DRAIN_T < 1) ? 1 : DRAIN_T;
  localparam int SPIN_E  = (SPIN_T  < 1) ? 1 : SPIN_T;

  phase_t          phase_q, phase_d, phase_dec;
  logic [PW-1:0]   pre_q, pre_d, pre_base;
  logic [CW-1:0]   elapsed_q, elapsed_d, el_base, dur;
  logic            done_q, done_d, done_base;
  logic            change, frozen, tick;

  always_comb begin
    phase_dec = IDLE;
    if (bus.Water)                  phase_dec = FILL;
    else if (bus.Agitator && !bus.R) phase_dec = WASH;
    else if (bus.Agitator)          phase_dec = RINSE;
    else if (bus.Motor)             phase_dec = SPIN;
    else if (bus.Pump)              phase_dec = DRAIN;
  end

  always_comb begin
    dur = CW'(1);
    case (phase_dec)
      FILL:    dur = CW'(FILL_E);
      WASH:    dur = CW'(WASH_E);
      RINSE:   dur = CW'(RINSE_E);
      DRAIN:   dur = CW'(DRAIN_E);
      SPIN:    dur = CW'(SPIN_E);
      default: dur = CW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= IDLE;
      pre_q     <= '0;
      elapsed_q <= '0;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pre_q     <= pre_d;
      elapsed_q <= elapsed_d;
      done_q    <= done_d;
    end
  end

  // A phase change clears the counters and still counts as the first cycle of the new phase.
  always_comb begin
    change    = (phase_dec != phase_q);
    frozen    = (phase_dec == SPIN) && bus.Door && !change;
    pre_base  = change ? '0 : pre_q;
    el_base   = change ? '0 : elapsed_q;
    done_base = change ? 1'b0 : done_q;
    phase_d   = phase_dec;
    pre_d     = pre_base;
    elapsed_d = el_base;
    done_d    = done_base;
    tick      = 1'b0;
    if (phase_dec == IDLE) begin
      pre_d     = '0;
      elapsed_d = '0;
      done_d    = 1'b0;
    end else if (!frozen) begin
      tick  = (pre_base == PRE_LAST);
      pre_d = tick ? '0 : pre_base + PW'(1);
      if (tick) begin
        elapsed_d = (&el_base) ? el_base : el_base + CW'(1);
        if (elapsed_d >= dur) done_d = 1'b1;
      end
    end
  end

  // Qualifying with the decoded phase keeps a stale flag away from the FSM on the change cycle.
  always_comb begin
    logic live;
    live   = done_q && (phase_dec == phase_q);
    bus.Tf = live && (phase_q == FILL);
    bus.Tw = live && (phase_q == WASH);
    bus.Tr = live && (phase_q == RINSE);
    bus.Td = live && (phase_q == DRAIN);
    bus.Ts = live && (phase_q == SPIN);
  end

endmodule

// File: tb/tb_washer_phase_timer.sv
// Directed bench: three timer instances (default, TICK_DIV=2, TICK_DIV=1) share one stimulus;
// expected flag vectors {Tf,Tw,Tr,Td,Ts} are queued per cycle and checked at the falling edge.
module tb_washer_phase_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic water = 1'b0, agit = 1'b0, rq = 1'b0, pump = 1'b0, motor = 1'b0, door = 1'b0;

  always #5 clk = ~clk;

  washer_phase_if ifd();
  washer_phase_if if2();
  washer_phase_if if1();

  assign ifd.Water = water; assign ifd.Agitator = agit; assign ifd.R = rq;
  assign ifd.Pump  = pump;  assign ifd.Motor    = motor; assign ifd.Door = door;
  assign if2.Water = water; assign if2.Agitator = agit; assign if2.R = rq;
  assign if2.Pump  = pump;  assign if2.Motor    = motor; assign if2.Door = door;
  assign if1.Water = water; assign if1.Agitator = agit; assign if1.R = rq;
  assign if1.Pump  = pump;  assign if1.Motor    = motor; assign if1.Door = door;

  washer_phase_timer dut_d (.clk(clk), .reset(reset), .bus(ifd.slave));
  washer_phase_timer #(.TICK_DIV(2), .FILL_T(3)) dut_2 (.clk(clk), .reset(reset), .bus(if2.slave));
  washer_phase_timer #(.TICK_DIV(1), .DRAIN_T(0)) dut_1 (.clk(clk), .reset(reset), .bus(if1.slave));

  localparam logic [4:0] F = 5'b10000, W = 5'b01000, RN = 5'b00100, D = 5'b00010, S = 5'b00001;
  localparam logic [4:0] NONE = 5'b00000;
  // actuator patterns {Water, Agitator, R, Pump, Motor}
  localparam logic [4:0] P_IDLE = 5'b00000, P_FILL = 5'b10000, P_WASH = 5'b01000;
  localparam logic [4:0] P_RINSE = 5'b01100, P_DRAIN = 5'b00010, P_SPIN = 5'b00011;

  typedef struct {
    int         sel;
    logic [4:0] exp;
    string      tag;
  } sb_t;

  sb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check_one();
    sb_t        e;
    logic [4:0] act;
    e = sb.pop_front();
    case (e.sel)
      1:       act = {if2.Tf, if2.Tw, if2.Tr, if2.Td, if2.Ts};
      2:       act = {if1.Tf, if1.Tw, if1.Tr, if1.Td, if1.Ts};
      default: act = {ifd.Tf, ifd.Tw, ifd.Tr, ifd.Td, ifd.Ts};
    endcase
    checks++;
    assert (act === e.exp) else begin
      errors++;
      $error("FAIL %s dut%0d: flags=%b expected=%b", e.tag, e.sel, act, e.exp);
    end
  endtask

  // Hold a pattern for n cycles; cycle index k = start+i within the phase, flag expected from k>=lat.
  task automatic hold(input string tag, input logic [4:0] pat, input logic dr, input int n,
                      input int start, input int lat, input logic [4:0] flag, input int sel);
    for (int i = 0; i < n; i++) begin
      {water, agit, rq, pump, motor} = pat;
      door = dr;
      sb.push_back('{sel, ((start + i) >= lat) ? flag : NONE, tag});
      @(negedge clk);
      check_one();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    hold("reset_d", P_IDLE, 1'b0, 2, 0, 99, NONE, 0);
    reset = 1'b0;
    hold("idle_2", P_IDLE, 1'b0, 1, 0, 99, NONE, 1);

    hold("fill_div2", P_FILL, 1'b0, 10, 0, 6, F, 1);
    hold("idle_div2", P_IDLE, 1'b0, 2, 0, 99, NONE, 1);

    hold("seq_fill1",  P_FILL,  1'b0, 14, 0, 12, F,  0);
    hold("seq_wash",   P_WASH,  1'b0, 18, 0, 16, W,  0);
    hold("seq_drain1", P_DRAIN, 1'b0, 10, 0, 8,  D,  0);
    hold("seq_fill2",  P_FILL,  1'b0, 14, 0, 12, F,  0);
    hold("seq_rinse",  P_RINSE, 1'b0, 18, 0, 16, RN, 0);
    hold("seq_drain2", P_DRAIN, 1'b0, 10, 0, 8,  D,  0);
    hold("seq_spin",   P_SPIN,  1'b0, 22, 0, 20, S,  0);
    hold("seq_idle",   P_IDLE,  1'b0, 3,  0, 99, NONE, 0);

    hold("spin_run",    P_SPIN, 1'b0, 8,  0,  27, S, 0);
    hold("spin_frozen", P_SPIN, 1'b1, 7,  8,  27, S, 0);
    hold("spin_resume", P_SPIN, 1'b0, 15, 15, 27, S, 0);
    for (int i = 0; i < 11; i++)
      hold("drain_door", P_DRAIN, logic'(i % 2), 1, i, 8, D, 0);
    hold("idle_b", P_IDLE, 1'b0, 2, 0, 99, NONE, 0);

    hold("fill_cut", P_FILL, 1'b0, 5,  0, 12, F, 0);
    hold("wash_aft", P_WASH, 1'b0, 18, 0, 16, W, 0);
    hold("idle_c",   P_IDLE, 1'b0, 2,  0, 99, NONE, 0);

    hold("wash_pre", P_WASH, 1'b0, 6, 0, 16, W, 0);
    reset = 1'b1;
    hold("wash_rst", P_WASH, 1'b0, 2, 0, 99, NONE, 0);
    reset = 1'b0;
    hold("wash_post", P_WASH, 1'b0, 18, 0, 16, W, 0);
    hold("idle_d",    P_IDLE, 1'b0, 2,  0, 99, NONE, 0);

    hold("drain_div1", P_DRAIN, 1'b0, 4, 0, 1, D, 2);
    hold("idle_div1",  P_IDLE,  1'b0, 2, 0, 99, NONE, 2);

    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL sb_drain: left=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
